// File: rtl/mdac_pkg.sv
// rtl/mdac_pkg.sv - shared types, constants and helpers for the MEDAC phase-selection path
package mdac_pkg;

    // Width of the per-direction qualifying-error counters.
    localparam int ERRC_W = 4;

    // Phase controller FSM encoding.
    typedef enum logic {
        ST_TRACK   = 1'b0,
        ST_HOLDOFF = 1'b1
    } psc_state_e;

    // Centre (origin) phase index for an odd number of phases.
    function automatic int centre_idx(input int num_phases);
        return (num_phases - 1) / 2;
    endfunction

endpackage

// File: rtl/err_qual_cnt.sv
// rtl/err_qual_cnt.sv - saturating qualifying-error counter with threshold hit
//
// Ports:
//   clk    - clock; the counter updates on the falling edge
//   rst_n  - asynchronous active-low reset
//   inc    - one qualifying error this cycle
//   clr    - clear the counter (wins over inc)
//   sat    - phase is at the limit for this direction; suppress hit
//   hit    - combinational: this increment brings the count to ERR_THRESH
module err_qual_cnt
    import mdac_pkg::*;
#(
    parameter int ERR_THRESH = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    input  logic sat,
    output logic hit
);

    localparam logic [ERRC_W-1:0] THR = ERRC_W'(ERR_THRESH);

    logic [ERRC_W-1:0] cnt;

    // hit is deliberately independent of clr: the parent folds hit back into
    // clr to empty the counter on a step, so a dependency would form a loop.
    assign hit = inc && (cnt == THR - 1'b1) && !sat;

    // At a limit the count is allowed to reach THR and then parks there.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != THR)) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phase_sel_ctrl.sv
// rtl/phase_sel_ctrl.sv - clock-phase selection controller for the MEDAC timing-error path
//
// Optional macro: PHASE_SEL_CTRL_FORCE_EN adds force_en / force_sel override ports.
//
// Ports:
//   clk           - controller clock; all state updates on the falling edge
//   rst_n         - asynchronous active-low reset
//   error_lagging - lagging sampler mismatch, requests a step to an earlier phase
//   error_origin  - origin sampler mismatch, informational only
//   error_leading - leading sampler mismatch, requests a step to a later phase
//   clk_sel       - registered selected phase index
//   sel_change    - one-cycle pulse in the cycle clk_sel changed
//   at_limit      - clk_sel is at index 0 or NUM_PHASES-1
//   conflict      - sticky: lagging and leading seen together while tracking
//   force_en      - (macro only) override the phase index
//   force_sel     - (macro only) forced index, clamped to NUM_PHASES-1
module phase_sel_ctrl
    import mdac_pkg::*;
#(
    parameter int NUM_PHASES = 5,
    parameter int ERR_THRESH = 3,
    parameter int HOLDOFF    = 4,
    parameter int SEL_W      = $clog2(NUM_PHASES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             error_lagging,
    input  logic             error_origin,
    input  logic             error_leading,
    output logic [SEL_W-1:0] clk_sel,
    output logic             sel_change,
    output logic             at_limit,
    output logic             conflict
`ifdef PHASE_SEL_CTRL_FORCE_EN
    ,
    input  logic             force_en,
    input  logic [SEL_W-1:0] force_sel
`endif
);

    localparam logic [SEL_W-1:0] MAX_IDX   = SEL_W'(NUM_PHASES - 1);
    localparam logic [SEL_W-1:0] CENTRE    = SEL_W'(centre_idx(NUM_PHASES));
    localparam logic [7:0]       HOLD_INIT = 8'(HOLDOFF);

    psc_state_e       state, state_nxt;
    logic [7:0]       hold_cnt, hold_nxt;
    logic [SEL_W-1:0] clk_sel_nxt;
    logic             sel_change_nxt;
    logic             conflict_nxt;

    logic             force_act;
    logic [SEL_W-1:0] force_val;

`ifdef PHASE_SEL_CTRL_FORCE_EN
    assign force_act = force_en;
    assign force_val = (force_sel > MAX_IDX) ? MAX_IDX : force_sel;
`else
    assign force_act = 1'b0;
    assign force_val = '0;
`endif

    // The origin sampler is observed by software elsewhere; it never steers.
    logic unused_origin;
    assign unused_origin = error_origin;

    logic track;
    logic lag_only, lead_only, both_err;
    logic early_hit, late_hit;
    logic early_clr, late_clr;

    assign track     = (state == ST_TRACK) && !force_act;
    assign lag_only  = track &&  error_lagging && !error_leading;
    assign lead_only = track && !error_lagging &&  error_leading;
    assign both_err  = track &&  error_lagging &&  error_leading;

    // Any error in the opposite direction, a conflict, a step, hold-off or a
    // forced index all restart qualification from zero.
    assign early_clr = !track || lead_only || both_err || early_hit || late_hit;
    assign late_clr  = !track || lag_only  || both_err || early_hit || late_hit;

    err_qual_cnt #(.ERR_THRESH(ERR_THRESH)) u_cnt_early (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lag_only),
        .clr   (early_clr),
        .sat   (clk_sel == '0),
        .hit   (early_hit)
    );

    err_qual_cnt #(.ERR_THRESH(ERR_THRESH)) u_cnt_late (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (lead_only),
        .clr   (late_clr),
        .sat   (clk_sel == MAX_IDX),
        .hit   (late_hit)
    );

    always_comb begin
        state_nxt    = state;
        hold_nxt     = hold_cnt;
        clk_sel_nxt  = clk_sel;
        conflict_nxt = conflict || both_err;

        if (force_act) begin
            state_nxt   = ST_TRACK;
            hold_nxt    = '0;
            clk_sel_nxt = force_val;
        end else begin
            case (state)
                ST_TRACK: begin
                    if (early_hit || late_hit) begin
                        clk_sel_nxt = early_hit ? (clk_sel - 1'b1) : (clk_sel + 1'b1);
                        if (HOLDOFF != 0) begin
                            state_nxt = ST_HOLDOFF;
                            hold_nxt  = HOLD_INIT;
                        end
                    end
                end
                ST_HOLDOFF: begin
                    // Leaving on the edge that sees 1 gives exactly HOLDOFF
                    // ignored edges after the step edge.
                    if (hold_cnt <= 8'd1) begin
                        state_nxt = ST_TRACK;
                        hold_nxt  = '0;
                    end else begin
                        hold_nxt = hold_cnt - 8'd1;
                    end
                end
                default: begin
                    state_nxt = ST_TRACK;
                    hold_nxt  = '0;
                end
            endcase
        end

        sel_change_nxt = (clk_sel_nxt != clk_sel);
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_TRACK;
            hold_cnt   <= '0;
            clk_sel    <= CENTRE;
            sel_change <= 1'b0;
            conflict   <= 1'b0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_nxt;
            clk_sel    <= clk_sel_nxt;
            sel_change <= sel_change_nxt;
            conflict   <= conflict_nxt;
        end
    end

    assign at_limit = (clk_sel == '0) || (clk_sel == MAX_IDX);

endmodule

// File: tb/tb_phase_sel_ctrl.sv
// tb/tb_phase_sel_ctrl.sv - scoreboard testbench for phase_sel_ctrl
module tb_phase_sel_ctrl;

    localparam int SEL_W = 3;

    logic             clk = 1'b1;
    logic             rst_n = 1'b0;
    logic             error_lagging = 1'b0;
    logic             error_origin = 1'b0;
    logic             error_leading = 1'b0;
    logic [SEL_W-1:0] clk_sel;
    logic             sel_change;
    logic             at_limit;
    logic             conflict;
`ifdef PHASE_SEL_CTRL_FORCE_EN
    logic             force_en = 1'b0;
    logic [SEL_W-1:0] force_sel = '0;
`endif

    phase_sel_ctrl #(
        .NUM_PHASES (5),
        .ERR_THRESH (3),
        .HOLDOFF    (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .error_lagging (error_lagging),
        .error_origin  (error_origin),
        .error_leading (error_leading),
        .clk_sel       (clk_sel),
        .sel_change    (sel_change),
        .at_limit      (at_limit),
        .conflict      (conflict)
`ifdef PHASE_SEL_CTRL_FORCE_EN
        ,
        .force_en      (force_en),
        .force_sel     (force_sel)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int sel;
        int edge_no;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   edge_n  = 0;

    always @(negedge clk) edge_n <= edge_n + 1;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every sel_change pulse must match the next queued step.
    always @(posedge clk) begin
        if (rst_n && sel_change) begin
            if (q.size() == 0) begin
                check("unexpected_sel_change", int'(clk_sel), -1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("step_clk_sel", int'(clk_sel), e.sel);
                check("step_edge", edge_n, e.edge_no);
            end
        end
    end

    // Drive one edge's worth of inputs; exp_sel >= 0 means this edge steps.
    task automatic drive(input logic lag, input logic org, input logic lead, input int exp_sel);
        exp_t e;
        @(posedge clk); #1;
        error_lagging = lag;
        error_origin  = org;
        error_leading = lead;
        if (exp_sel >= 0) begin
            e.sel     = exp_sel;
            e.edge_no = edge_n + 1;
            q.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, -1);
    endtask

    task automatic sample();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #22;
        check("rst_clk_sel", int'(clk_sel), 2);
        check("rst_sel_change", int'(sel_change), 0);
        check("rst_at_limit", int'(at_limit), 0);
        check("rst_conflict", int'(conflict), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset mid-HOLDOFF
        drive(1, 0, 0, -1);
        drive(1, 0, 0, -1);
        drive(1, 0, 0, 1);
        @(posedge clk); #1;
        error_lagging = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midhold_rst_clk_sel", int'(clk_sel), 2);
        check("midhold_rst_sel_change", int'(sel_change), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(1, 0, 0, -1);
        drive(1, 0, 0, -1);
        drive(1, 0, 0, 1);
        idle(5);
        check("after_rst_clk_sel", int'(clk_sel), 1);

        // Threshold with a gap, down to the early limit
        drive(1, 0, 0, -1);
        drive(1, 0, 0, -1);
        drive(0, 0, 0, -1);
        drive(1, 0, 0, 0);
        idle(5);
        check("early_limit_clk_sel", int'(clk_sel), 0);
        check("early_at_limit", int'(at_limit), 1);
        for (int i = 0; i < 6; i++) drive(1, 0, 0, -1);
        idle(2);
        check("early_limit_hold", int'(clk_sel), 0);

        // Back to centre via leading errors
        drive(0, 0, 1, -1);
        drive(0, 0, 1, -1);
        drive(0, 0, 1, 1);
        idle(5);
        check("lead_clk_sel_1", int'(clk_sel), 1);
        check("mid_at_limit", int'(at_limit), 0);
        drive(0, 0, 1, -1);
        drive(0, 0, 1, -1);
        drive(0, 0, 1, 2);
        idle(5);

        // Direction reset
        drive(1, 0, 0, -1);
        drive(1, 0, 0, -1);
        drive(0, 0, 1, -1);
        drive(1, 0, 0, -1);
        drive(1, 0, 0, -1);
        idle(1);
        check("dir_reset_no_step", int'(clk_sel), 2);
        drive(1, 0, 0, 1);
        idle(5);
        check("dir_reset_step", int'(clk_sel), 1);

        // Hold-off spacing: step to 2, then to 3, then continuous leading
        drive(0, 0, 1, -1);
        drive(0, 0, 1, -1);
        drive(0, 0, 1, 2);
        idle(5);
        drive(0, 0, 1, -1);
        drive(0, 0, 1, -1);
        drive(0, 0, 1, 3);
        for (int i = 1; i <= 7; i++) drive(0, 0, 1, (i == 7) ? 4 : -1);
        for (int i = 0; i < 8; i++) drive(0, 0, 1, -1);
        idle(1);
        check("late_limit_clk_sel", int'(clk_sel), 4);
        check("late_at_limit", int'(at_limit), 1);

        // Conflict: sticky, clears counters, never steps
        drive(1, 0, 0, -1);
        drive(1, 0, 0, -1);
        drive(1, 0, 1, -1);
        sample();
        check("conflict_set", int'(conflict), 1);
        check("conflict_no_step", int'(clk_sel), 4);
        drive(1, 0, 0, -1);
        drive(1, 0, 0, -1);
        idle(1);
        check("conflict_cleared_counts", int'(clk_sel), 4);
        drive(1, 0, 0, 3);
        idle(5);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, -1);
        idle(1);
        check("origin_only", int'(clk_sel), 3);
        check("conflict_sticky", int'(conflict), 1);

`ifdef PHASE_SEL_CTRL_FORCE_EN
        // Force with clamp, then release and track from the forced index
        begin
            exp_t e;
            @(posedge clk); #1;
            force_en  = 1'b1;
            force_sel = 3'd7;
            e.sel     = 4;
            e.edge_no = edge_n + 1;
            q.push_back(e);
        end
        idle(3);
        check("force_clk_sel", int'(clk_sel), 4);
        @(posedge clk); #1;
        force_en = 1'b0;
        drive(1, 0, 0, -1);
        drive(1, 0, 0, -1);
        drive(1, 0, 0, 3);
        idle(5);
        check("force_release_step", int'(clk_sel), 3);
`endif

        idle(3);
        check("scoreboard_drained", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sel_ctrl.md
Name: phase_sel_ctrl

Overview:
- Parametrised clock-phase selection controller for the MEDAC timing-error path.
- Consumes per-cycle error flags from the leading, origin and lagging shadow samplers of the currently selected phase and steers a binary phase index across NUM_PHASES equally spaced clock phases.
- Supersedes the fixed 3-phase controller. Adds error-count thresholds, a post-switch hold-off window, limit reporting and conflict detection.
- Sits between the error detectors and the clock-phase mux.

Parameters:
- NUM_PHASES, 5, number of selectable phases. Odd, ≥3. Index 0 = earliest phase.
- ERR_THRESH, 3, qualifying error cycles needed before a step. Range 1..15.
- HOLDOFF, 4, cycles after a step during which error inputs are ignored. Range 0..255.
- SEL_W, $clog2(NUM_PHASES), width of clk_sel.

Ports:
- clk, input, 1, controller clock. All state updates on the falling edge, matching the detector timing.
- rst_n, input, 1, asynchronous active-low reset.
- error_lagging, input, 1, lagging sampler mismatch. Requests a step to an earlier phase (index−1).
- error_origin, input, 1, origin sampler mismatch. Counted only; never causes a step by itself.
- error_leading, input, 1, leading sampler mismatch. Requests a step to a later phase (index+1).
- clk_sel, output, SEL_W, selected phase index.
- sel_change, output, 1, one-cycle pulse in the cycle clk_sel changes.
- at_limit, output, 1, high while clk_sel is 0 or NUM_PHASES−1.
- conflict, output, 1, sticky flag: error_lagging and error_leading were both seen in one TRACK cycle. Cleared only by reset.

Behaviour:
- Reset (async, rst_n=0):
  - clk_sel = (NUM_PHASES−1)/2 (centre/origin).
  - sel_change=0, conflict=0, counters=0, state=TRACK.
  - at_limit=0 (it is combinational from clk_sel).
  - Reset asserted mid-HOLDOFF or mid-count aborts the activity immediately.
- Two saturating counters of width 4: cnt_early (driven by lagging errors) and cnt_late (driven by leading errors).
- FSM state TRACK, each falling edge:
  - error_lagging=1 and error_leading=0: cnt_early+1, cnt_late=0.
  - error_leading=1 and error_lagging=0: cnt_late+1, cnt_early=0.
  - Both=1: conflict←1, both counters cleared, no step.
  - Neither: counters hold.
  - error_origin never changes the counters.
  - When an increment makes a counter reach ERR_THRESH:
    - If not at the corresponding limit: clk_sel steps by one in the same edge, sel_change=1 for that cycle, both counters clear, go to HOLDOFF. With HOLDOFF=0, stay in TRACK instead.
    - If clk_sel is already at the limit (0 for early, NUM_PHASES−1 for late): no step, no sel_change, counter saturates at ERR_THRESH.
- FSM state HOLDOFF:
  - Down-counter loaded with HOLDOFF on entry. Error inputs are ignored and counters stay 0.
  - Returns to TRACK on the edge where the down-counter reaches 1. This gives exactly HOLDOFF ignored cycles after the step edge.
- Latency: the step happens on the same edge that samples the ERR_THRESH-th qualifying error. clk_sel is registered, so there is no combinational input→output path except at_limit←clk_sel.
- clk_sel never leaves 0..NUM_PHASES−1. No wrap-around.

Optional Feature:
- Macro: PHASE_SEL_CTRL_FORCE_EN.
- With the macro defined, two extra ports are added: force_en (input, 1) and force_sel (input, SEL_W).
  - While force_en=1: clk_sel←force_sel each edge, with out-of-range values clamped to NUM_PHASES−1. Counters clear and the FSM is held in TRACK.
  - sel_change pulses whenever the forced value differs from the current clk_sel.
  - On release (force_en 1→0), tracking resumes from the forced index with counters at 0.
- Without the macro: those ports are absent and the logic is removed.

Decomposition:
- Shared package mdac_pkg:
  - FSM state encoding: TRACK=1'b0, HOLDOFF=1'b1.
  - Counter width constant ERRC_W=4.
  - Centre-index function centre_idx(NUM_PHASES).
- Natural sub-module err_qual_cnt: one instance per direction. It holds the saturating counter with inc/clr/sat inputs and a hit output at ERR_THRESH.

Test Plan:
- Reset: with NUM_PHASES=5, assert rst_n=0 mid-HOLDOFF → clk_sel=2 and sel_change=0 immediately; after release, 3 lagging errors → clk_sel=1.
- Threshold: ERR_THRESH=3. Apply error_lagging for 2 cycles, 1 idle, then 1 more → clk_sel 2→1 on the 3rd error edge, sel_change pulses exactly 1 cycle. Repeat until clk_sel=0 → at_limit=1; further lagging errors produce no change.
- Direction reset: 2 lagging errors, then 1 leading error, then 2 lagging errors → no step. A 3rd lagging error → clk_sel=1.
- Hold-off: HOLDOFF=4. Step to 3 via leading errors, then continuous error_leading → the next step lands exactly 4+3 edges after the first.
- Conflict: error_lagging=error_leading=1 for one cycle → conflict=1 and stays 1, no step. error_origin alone for 20 cycles → clk_sel unchanged.
- Force (FORCE_EN defined): force_en=1, force_sel=7 → clk_sel=4 with one sel_change pulse. Release, then 3 lagging errors → clk_sel=3.
